// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS32 main control unit:
// state encoding, opcode/function constants, ALU operation encoding,
// datapath select values and the registered control-word layout.
package mc_ctrl_pkg;

  localparam int ALU_OP_W = 4;

  // 4-bit state encoding, also exported on the State debug port.
  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EXE_R    = 4'd2,
    S_WB_R     = 4'd3,
    S_EXE_I    = 4'd4,
    S_WB_I     = 4'd5,
    S_EXE_ADDR = 4'd6,
    S_MEM_LD   = 4'd7,
    S_WB_LD    = 4'd8,
    S_MEM_ST   = 4'd9,
    S_EXE_BR   = 4'd10,
    S_EXE_J    = 4'd11,
    S_ILL      = 4'd12
  } state_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_LUI = 4'd7
  } alu_op_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // PC_Source
  localparam logic [1:0] PCS_PC4 = 2'd0;
  localparam logic [1:0] PCS_BR  = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;

  // Reg_Dst
  localparam logic [1:0] RDST_RT  = 2'd0;
  localparam logic [1:0] RDST_RD  = 2'd1;
  localparam logic [1:0] RDST_R31 = 2'd2;

  // Mem_To_Reg
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // ALU_Src_B
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // Complete control word, registered as one unit.
  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    alu_op_e    alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the main control unit (master) and the datapath
// (slave). Build with PERF_CNT_EN defined to add the performance counters.
interface mc_control_fsm_if;
  import mc_ctrl_pkg::*;

  logic [5:0]          OP_Code;
  logic [5:0]          Func;
  logic                Zero;
  logic                IR_Write;
  logic                PC_Write;
  logic                PC_Write_Cond;
  logic                Branch_Ne;
  logic [1:0]          PC_Source;
  logic                Mem_Read;
  logic                Mem_Write;
  logic                Reg_Write;
  logic [1:0]          Reg_Dst;
  logic [1:0]          Mem_To_Reg;
  logic                ALU_Src_A;
  logic [1:0]          ALU_Src_B;
  logic                Ext_Op;
  logic [ALU_OP_W-1:0] ALU_Op;
  logic                Illegal;
  logic [3:0]          State;
`ifdef PERF_CNT_EN
  logic [31:0]         Cycle_Cnt;
  logic [31:0]         Inst_Cnt;
`endif

  modport master (
    input  OP_Code, Func, Zero,
    output IR_Write, PC_Write, PC_Write_Cond, Branch_Ne, PC_Source,
           Mem_Read, Mem_Write, Reg_Write, Reg_Dst, Mem_To_Reg,
           ALU_Src_A, ALU_Src_B, Ext_Op, ALU_Op, Illegal, State
`ifdef PERF_CNT_EN
    , output Cycle_Cnt, Inst_Cnt
`endif
  );

  modport slave (
    output OP_Code, Func, Zero,
    input  IR_Write, PC_Write, PC_Write_Cond, Branch_Ne, PC_Source,
           Mem_Read, Mem_Write, Reg_Write, Reg_Dst, Mem_To_Reg,
           ALU_Src_A, ALU_Src_B, Ext_Op, ALU_Op, Illegal, State
`ifdef PERF_CNT_EN
    , input Cycle_Cnt, Inst_Cnt
`endif
  );

endinterface

// File: rtl/mc_alu_decode.sv
// Combinational ALU operation decode: R-type function field or I-type
// opcode to ALU_Op and immediate extension mode, plus R-type legality.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] func,
  output alu_op_e    alu_op,
  output logic       ext_op,
  output logic       func_legal
);

  // Map the instruction fields to the ALU operation it executes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    func_legal = 1'b0;
    if (op_code == OP_RTYPE) begin
      func_legal = 1'b1;
      case (func)
        FN_ADD:  alu_op = ALU_ADD;
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRL:  alu_op = ALU_SRL;
        default: func_legal = 1'b0;
      endcase
    end else begin
      case (op_code)
        OP_ADDI: begin alu_op = ALU_ADD; ext_op = 1'b1; end
        OP_ORI:  alu_op = ALU_OR;
        OP_LUI:  alu_op = ALU_LUI;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS32 main control FSM (IF/ID/EXE/MEM/WB). The control word
// for the next state is computed combinationally and registered, so every
// output is a clean flop. Write strobes are additionally masked while rst
// is high so an interrupted instruction cannot commit anything.
// Optional feature macro: PERF_CNT_EN (cycle and instruction counters).
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter state_e RESET_STATE = S_IF
) (
  input  logic                 clk,
  input  logic                 rst,
  mc_control_fsm_if.master     bus
);

  state_e  state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d, ctrl_rst;
  alu_op_e dec_alu_op;
  logic    dec_ext_op;
  logic    dec_func_legal;

  mc_alu_decode u_alu_decode (
    .op_code    (bus.OP_Code),
    .func       (bus.Func),
    .alu_op     (dec_alu_op),
    .ext_op     (dec_ext_op),
    .func_legal (dec_func_legal)
  );

  // Control word asserted while the FSM sits in state s.
  function automatic ctrl_t decode_ctrl(input state_e s, input logic [5:0] op,
                                        input alu_op_e dec_op, input logic dec_ext);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.ir_write  = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_PC4;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.ext_op    = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      S_EXE_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = dec_op;
      end
      S_WB_R: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RD;
        c.mem_to_reg = M2R_ALU;
        c.alu_op     = dec_op;
      end
      S_EXE_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = dec_op;
        c.ext_op    = dec_ext;
      end
      S_WB_I: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = M2R_ALU;
      end
      S_EXE_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.ext_op    = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_LD: c.mem_read  = 1'b1;
      S_WB_LD: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = RDST_RT;
        c.mem_to_reg = M2R_MEM;
      end
      S_MEM_ST: c.mem_write = 1'b1;
      S_EXE_BR: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCS_BR;
        c.branch_ne     = (op == OP_BNE);
      end
      S_EXE_J: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JMP;
        if (op == OP_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = RDST_R31;
          c.mem_to_reg = M2R_PC4;
        end
      end
      S_ILL:   c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection; S_ID dispatches on the freshly loaded opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (bus.OP_Code)
          OP_RTYPE:              state_d = dec_func_legal ? S_EXE_R : S_ILL;
          OP_LW, OP_SW:          state_d = S_EXE_ADDR;
          OP_BEQ, OP_BNE:        state_d = S_EXE_BR;
          OP_J, OP_JAL:          state_d = S_EXE_J;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXE_I;
          default:               state_d = S_ILL;
        endcase
      end
      S_EXE_R:    state_d = S_WB_R;
      S_EXE_I:    state_d = S_WB_I;
      S_EXE_ADDR: state_d = (bus.OP_Code == OP_SW) ? S_MEM_ST : S_MEM_LD;
      S_MEM_LD:   state_d = S_WB_LD;
      S_WB_R, S_WB_I, S_WB_LD, S_MEM_ST, S_EXE_BR, S_EXE_J: state_d = S_IF;
      S_ILL:      state_d = S_ILL;
      default:    state_d = RESET_STATE;
    endcase
  end

  // Control words for the upcoming state and for the reset state.
  always_comb begin
    ctrl_d   = decode_ctrl(state_d, bus.OP_Code, dec_alu_op, dec_ext_op);
    ctrl_rst = decode_ctrl(RESET_STATE, bus.OP_Code, dec_alu_op, dec_ext_op);
  end

  // State register and registered control word, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= RESET_STATE;
      ctrl_q  <= ctrl_rst;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.IR_Write      = ctrl_q.ir_write      & ~rst;
  assign bus.PC_Write      = ctrl_q.pc_write      & ~rst;
  assign bus.PC_Write_Cond = ctrl_q.pc_write_cond & ~rst;
  assign bus.Mem_Write     = ctrl_q.mem_write     & ~rst;
  assign bus.Reg_Write     = ctrl_q.reg_write     & ~rst;
  assign bus.Mem_Read      = ctrl_q.mem_read;
  assign bus.Branch_Ne     = ctrl_q.branch_ne;
  assign bus.PC_Source     = ctrl_q.pc_source;
  assign bus.Reg_Dst       = ctrl_q.reg_dst;
  assign bus.Mem_To_Reg    = ctrl_q.mem_to_reg;
  assign bus.ALU_Src_A     = ctrl_q.alu_src_a;
  assign bus.ALU_Src_B     = ctrl_q.alu_src_b;
  assign bus.Ext_Op        = ctrl_q.ext_op;
  assign bus.ALU_Op        = ctrl_q.alu_op;
  assign bus.Illegal       = ctrl_q.illegal;
  assign bus.State         = state_q;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  // Cycles count outside S_ILL; instructions count on each return to S_IF.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    if (state_q != S_ILL) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (state_d == S_IF)  inst_cnt_d  = inst_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset and wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  assign bus.Cycle_Cnt = cycle_cnt_q;
  assign bus.Inst_Cnt  = inst_cnt_q;
`endif

endmodule
